// File: rtl/debug_pkg.sv
// Shared command/reply codes, FSM state encoding and status-byte layout
// for the debugger command sequencer.
package debug_pkg;

    localparam logic [7:0] CMD_READ   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_LED    = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_ECHO   = 8'h45;  // 'E'
    localparam logic [7:0] CMD_STATUS = 8'h53;  // 'S'

    localparam logic [7:0] RPL_OK  = 8'h4B;     // 'K'
    localparam logic [7:0] RPL_ERR = 8'h3F;     // '?'

    localparam int STAT_OVR = 7;
    localparam int STAT_UNK = 6;
    localparam int STAT_TMO = 5;

    // One-hot so TX_START can come straight off a single state flop.
    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        ARG     = 5'b00010,
        SEND    = 5'b00100,
        WAIT_HI = 5'b01000,
        WAIT_LO = 5'b10000
    } state_t;

    localparam int SEND_BIT = 2;

    function automatic logic [7:0] status_byte(input logic ovr, input logic unk,
                                               input logic tmo, input logic [3:0] leds);
        logic [7:0] b;
        b           = {4'b0000, leds};
        b[STAT_OVR] = ovr;
        b[STAT_UNK] = unk;
        b[STAT_TMO] = tmo;
        return b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, parameterised width.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Debugger command sequencer: decodes UART command bytes, drives the LED
// register and sends exactly one reply byte per command via start/busy.
//
// state   | meaning
// IDLE    | waiting for a command byte
// ARG     | waiting for the argument byte of 'L'/'E', timeout running
// SEND    | reply loaded, TX_START fires once the transmitter is free
// WAIT_HI | waiting for TX_BUSY to rise
// WAIT_LO | waiting for TX_BUSY to fall
module debug_cmd_ctrl
    import debug_pkg::*;
#(
    parameter int PROBE_W     = 8,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic               iCE_CLK,
    input  logic               RST,
    input  logic               RECEIVED,
    input  logic [7:0]         REC_BYTE,
    input  logic [PROBE_W-1:0] PROBE,
    input  logic               TX_BUSY,
    output logic               TX_START,
    output logic [7:0]         TX_BYTE,
    output logic [3:0]         LEDS,
    output logic               ERR
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state, state_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [3:0]         leds_q, leds_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               arg_led_q, arg_led_d;
    logic               status_q, status_d;
    logic               ovr_q, unk_q, tmo_q, err_q;
    logic               ovr_set, unk_set, tmo_set, flag_clr;
    logic               tx_start;
    logic [PROBE_W-1:0] probe_sync;
    logic [7:0]         probe_ext;

    sync2 #(.W(PROBE_W)) u_probe_sync (
        .clk (iCE_CLK),
        .rst (RST),
        .d   (PROBE),
        .q   (probe_sync)
    );

    always_comb begin
        probe_ext                = '0;
        probe_ext[PROBE_W-1:0]   = probe_sync;
    end

    assign tx_start = state[SEND_BIT] & ~TX_BUSY;

    always_comb begin
        state_d   = state;
        tx_byte_d = tx_byte_q;
        leds_d    = leds_q;
        cnt_d     = cnt_q;
        arg_led_d = arg_led_q;
        status_d  = status_q;
        ovr_set   = 1'b0;
        unk_set   = 1'b0;
        tmo_set   = 1'b0;
        flag_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (RECEIVED) begin
                    status_d = 1'b0;
                    state_d  = SEND;
                    case (REC_BYTE)
                        CMD_READ:   tx_byte_d = probe_ext;
                        CMD_LED, CMD_ECHO: begin
                            arg_led_d = (REC_BYTE == CMD_LED);
                            cnt_d     = '0;
                            state_d   = ARG;
                        end
                        CMD_STATUS: begin
                            tx_byte_d = status_byte(ovr_q, unk_q, tmo_q, leds_q);
                            status_d  = 1'b1;
                        end
                        default: begin
                            unk_set   = 1'b1;
                            tx_byte_d = RPL_ERR;
                        end
                    endcase
                end
            end
            ARG: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An argument arriving on the expiry cycle still wins.
                if (RECEIVED) begin
                    state_d = SEND;
                    if (arg_led_q) begin
                        leds_d    = REC_BYTE[3:0];
                        tx_byte_d = RPL_OK;
                    end else begin
                        tx_byte_d = REC_BYTE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    tmo_set   = 1'b1;
                    tx_byte_d = RPL_ERR;
                    state_d   = SEND;
                end
            end
            SEND: begin
                ovr_set = RECEIVED;
                if (tx_start) begin
                    flag_clr = status_q;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                ovr_set = RECEIVED;
                if (TX_BUSY) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                ovr_set = RECEIVED;
                if (!TX_BUSY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCE_CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            tx_byte_q <= '0;
            leds_q    <= '0;
            cnt_q     <= '0;
            arg_led_q <= 1'b0;
            status_q  <= 1'b0;
            ovr_q     <= 1'b0;
            unk_q     <= 1'b0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            tx_byte_q <= tx_byte_d;
            leds_q    <= leds_d;
            cnt_q     <= cnt_d;
            arg_led_q <= arg_led_d;
            status_q  <= status_d;
            ovr_q     <= (ovr_q & ~flag_clr) | ovr_set;
            unk_q     <= (unk_q & ~flag_clr) | unk_set;
            tmo_q     <= (tmo_q & ~flag_clr) | tmo_set;
            err_q     <= ovr_q | unk_q | tmo_q;
        end
    end

    assign TX_START = tx_start;
    assign TX_BYTE  = tx_byte_q;
    assign LEDS     = leds_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Bench for debug_cmd_ctrl: directed scenarios plus randomized commands
// checked against a command-level reply model and a simple transmitter model.
module tb_debug_cmd_ctrl;
    import debug_pkg::*;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rec_byte = 8'h00;
    logic [7:0] probe = 8'h00;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [3:0] leds;
    logic       err;

    logic busy_model = 1'b0;
    logic hold_busy  = 1'b0;
    assign tx_busy = busy_model | hold_busy;

    always #5 clk = ~clk;

    debug_cmd_ctrl #(.PROBE_W(8), .TIMEOUT_CYC(TMO)) dut (
        .iCE_CLK  (clk),
        .RST      (rst),
        .RECEIVED (received),
        .REC_BYTE (rec_byte),
        .PROBE    (probe),
        .TX_BUSY  (tx_busy),
        .TX_START (tx_start),
        .TX_BYTE  (tx_byte),
        .LEDS     (leds),
        .ERR      (err)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Transmitter model: busy rises the cycle after TX_START, for busy_len cycles.
    int         busy_len = 4;
    int         busy_rem = 0;
    int         unstable = 0;
    int         starts = 0;
    logic       seen_start = 1'b0;
    logic [7:0] cap_byte = 8'h00;
    logic [7:0] rep_q[$];
    int         rep_cyc_q[$];

    always @(negedge clk) begin
        seen_start = tx_start;
        if (tx_start === 1'b1) begin
            rep_q.push_back(tx_byte);
            rep_cyc_q.push_back(cyc);
            cap_byte = tx_byte;
            starts++;
        end else if (busy_model && !rst && tx_byte !== cap_byte) begin
            unstable++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (seen_start === 1'b1) busy_rem = busy_len;
        else if (busy_rem > 0) busy_rem--;
        busy_model = (busy_rem > 0);
    end

    int passed = 0, total = 0, fails = 0;
    int exp_starts = 0;
    logic       m_ovr = 1'b0, m_unk = 1'b0, m_tmo = 1'b0;
    logic [3:0] m_leds = 4'h0;
    logic [7:0] m_probe = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        received = 1'b1;
        rec_byte = b;
        tick();
        received = 1'b0;
    endtask

    task automatic set_probe(input logic [7:0] v);
        probe   = v;
        m_probe = v;
        repeat (3) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && tx_busy; i++) tick();
        check("busy_drop", tx_busy, 1'b0);
        repeat (2) tick();
    endtask

    task automatic do_cmd(input logic [7:0] c, input bit give_arg, input logic [7:0] a,
                          input int dly, input bit inj, input int blen);
        logic [7:0] exp_b;
        int         t0, exp_cyc, s_cyc;
        logic [7:0] got;
        busy_len = blen;
        exp_starts++;
        if (c == CMD_READ) exp_b = m_probe;
        else if (c == CMD_LED || c == CMD_ECHO) begin
            if (!give_arg) begin
                m_tmo = 1'b1;
                exp_b = RPL_ERR;
            end else if (c == CMD_LED) begin
                m_leds = a[3:0];
                exp_b  = RPL_OK;
            end else exp_b = a;
        end else if (c == CMD_STATUS) begin
            exp_b = {m_ovr, m_unk, m_tmo, 1'b0, m_leds};
            m_ovr = 1'b0; m_unk = 1'b0; m_tmo = 1'b0;
        end else begin
            m_unk = 1'b1;
            exp_b = RPL_ERR;
        end
        t0 = cyc;
        send_byte(c);
        exp_cyc = t0 + 1;
        if (c == CMD_LED || c == CMD_ECHO) begin
            if (give_arg) begin
                repeat (dly) tick();
                exp_cyc = cyc + 1;
                send_byte(a);
                check("leds_at_arg", leds, m_leds);
            end else exp_cyc = t0 + TMO + 1;
        end
        for (int i = 0; i < 100 && rep_q.size() == 0; i++) tick();
        check("reply_count", rep_q.size(), 1);
        if (rep_q.size() > 0) begin
            got   = rep_q.pop_front();
            s_cyc = rep_cyc_q.pop_front();
            check("reply_byte", got, exp_b);
            check("reply_cycle", s_cyc, exp_cyc);
        end
        if (inj) begin
            send_byte(CMD_READ);
            m_ovr = 1'b1;
        end
        wait_idle();
        check("starts", starts, exp_starts);
        check("leds", leds, m_leds);
        check("err", err, m_ovr | m_unk | m_tmo);
    endtask

    initial begin
        logic [7:0] c, a;
        int         sel;
        logic [7:0] got;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_leds", leds, 4'h0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        set_probe(8'hA5);
        do_cmd(CMD_READ, 0, 8'h00, 0, 0, 20);

        do_cmd(CMD_LED, 1, 8'h3C, 5, 0, 6);
        do_cmd(CMD_STATUS, 0, 8'h00, 0, 0, 4);

        do_cmd(CMD_ECHO, 0, 8'h00, 0, 0, 4);
        do_cmd(CMD_STATUS, 0, 8'h00, 0, 0, 4);

        do_cmd(8'h7A, 0, 8'h00, 0, 0, 5);
        set_probe(8'h3E);
        do_cmd(CMD_READ, 0, 8'h00, 0, 1, 8);
        do_cmd(CMD_STATUS, 0, 8'h00, 0, 0, 4);

        do_cmd(CMD_ECHO, 1, 8'hD7, TMO - 1, 0, 3);
        do_cmd(CMD_LED, 1, 8'h05, 0, 0, 3);
        do_cmd(CMD_STATUS, 0, 8'h00, 0, 0, 3);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 4);
            a   = 8'($urandom);
            case (sel)
                0: c = CMD_READ;
                1: c = CMD_LED;
                2: c = CMD_ECHO;
                3: c = CMD_STATUS;
                default: begin
                    c = 8'($urandom);
                    while (c == CMD_READ || c == CMD_LED || c == CMD_ECHO || c == CMD_STATUS)
                        c = 8'($urandom);
                end
            endcase
            if (c == CMD_READ) set_probe(8'($urandom));
            do_cmd(c, ($urandom_range(0, 3) != 0), a, $urandom_range(0, TMO - 1),
                   ($urandom_range(0, 3) == 0), $urandom_range(3, 10));
        end

        do_cmd(CMD_LED, 1, 8'h06, 2, 0, 4);
        do_cmd(8'h00, 0, 8'h00, 0, 0, 4);
        check("tx_byte_stable", unstable, 0);

        hold_busy = 1'b1;
        busy_len  = 10;
        set_probe(8'h5A);
        send_byte(CMD_READ);
        exp_starts++;
        repeat (4) tick();
        check("defer_starts", starts, exp_starts - 1);
        check("defer_tx_start", tx_start, 1'b0);
        check("defer_tx_byte", tx_byte, 8'h5A);
        hold_busy = 1'b0;
        #1;
        check("release_tx_start", tx_start, 1'b1);
        for (int i = 0; i < 20 && rep_q.size() == 0; i++) tick();
        check("hold_reply_count", rep_q.size(), 1);
        if (rep_q.size() > 0) begin
            got = rep_q.pop_front();
            void'(rep_cyc_q.pop_front());
            check("hold_reply_byte", got, 8'h5A);
        end
        repeat (2) tick();
        check("pre_rst_leds", leds, m_leds);
        check("pre_rst_err", err, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_tx_start", tx_start, 1'b0);
        check("arst_tx_byte", tx_byte, 8'h00);
        check("arst_leds", leds, 4'h0);
        check("arst_err", err, 1'b0);
        tick();
        rst = 1'b0;
        m_ovr = 1'b0; m_unk = 1'b0; m_tmo = 1'b0; m_leds = 4'h0;
        wait_idle();
        do_cmd(CMD_STATUS, 0, 8'h00, 0, 0, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
